// File: rtl/phv_result_collector_if.sv
// PHV/ALU handshake bundle for the stage result collector.
// slave = collector side; master = the stage driving PHVs and ALU results.
interface phv_result_collector_if #(
  parameter int unsigned NUM_ALU    = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PHV_WIDTH  = 1024
);
  logic [PHV_WIDTH-1:0]          phv_in;
  logic [NUM_ALU-1:0]            phv_in_mask;
  logic                          phv_in_valid;
  logic                          phv_in_ready;
  logic [NUM_ALU*DATA_WIDTH-1:0] alu_result;
  logic [NUM_ALU-1:0]            alu_result_valid;
  logic [NUM_ALU-1:0]            alu_ready;
  logic [PHV_WIDTH-1:0]          phv_out;
  logic                          phv_out_valid;
  logic                          phv_out_ready;
  logic                          err_unexpected;
  logic                          err_timeout;

  modport master (
    output phv_in, phv_in_mask, phv_in_valid, alu_result, alu_result_valid, phv_out_ready,
    input  phv_in_ready, alu_ready, phv_out, phv_out_valid, err_unexpected, err_timeout
  );

  modport slave (
    input  phv_in, phv_in_mask, phv_in_valid, alu_result, alu_result_valid, phv_out_ready,
    output phv_in_ready, alu_ready, phv_out, phv_out_valid, err_unexpected, err_timeout
  );
endinterface

// File: rtl/phv_result_collector.sv
// Collects per-ALU container results into the stage PHV and hands the merged
// PHV downstream; a COLLECT timeout forces the PHV out if an ALU never answers.
module phv_result_collector #(
  parameter int unsigned NUM_ALU        = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PHV_WIDTH      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMO_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  phv_result_collector_if.slave  bus
);

  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  state_e               state_q;
  logic [NUM_ALU-1:0]   pending_q;
  logic [NUM_ALU-1:0]   pending_d;
  logic [NUM_ALU-1:0]   capture;
  logic [NUM_ALU-1:0]   alu_ready_q;
  logic [PHV_WIDTH-1:0] phv_q;
  logic [PHV_WIDTH-1:0] phv_d;
  logic [TMO_W-1:0]     cnt_q;
  logic                 phv_in_ready_q;
  logic                 phv_out_valid_q;
  logic                 err_unexp_q;
  logic                 err_tmo_q;
  logic                 timeout_hit;
  logic                 unexpected;

  // Merge this cycle's results for still-pending ALUs; upper PHV bits untouched.
  always_comb begin
    capture     = bus.alu_result_valid & pending_q;
    pending_d   = pending_q & ~bus.alu_result_valid;
    unexpected  = |(bus.alu_result_valid & ~pending_q);
    phv_d       = phv_q;
    for (int i = 0; i < int'(NUM_ALU); i++) begin
      if (capture[i]) begin
        phv_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.alu_result[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    timeout_hit = TMO_EN && (cnt_q == TMO_LAST) && (pending_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      pending_q       <= '0;
      alu_ready_q     <= '0;
      phv_q           <= '0;
      cnt_q           <= '0;
      phv_in_ready_q  <= 1'b1;
      phv_out_valid_q <= 1'b0;
      err_unexp_q     <= 1'b0;
      err_tmo_q       <= 1'b0;
    end else begin
      if (unexpected) begin
        err_unexp_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.phv_in_valid) begin
            phv_q          <= bus.phv_in;
            pending_q      <= bus.phv_in_mask;
            cnt_q          <= '0;
            phv_in_ready_q <= 1'b0;
            if (bus.phv_in_mask == '0) begin
              state_q         <= OUTPUT;
              phv_out_valid_q <= 1'b1;
            end else begin
              state_q     <= COLLECT;
              alu_ready_q <= bus.phv_in_mask;
            end
          end
        end
        COLLECT: begin
          phv_q <= phv_d;
          cnt_q <= cnt_q + TMO_W'(1);
          // Timeout still keeps this cycle's captures; missing slots stay at phv_in.
          if ((pending_d == '0) || timeout_hit) begin
            state_q         <= OUTPUT;
            phv_out_valid_q <= 1'b1;
            alu_ready_q     <= '0;
            pending_q       <= '0;
            if (timeout_hit) begin
              err_tmo_q <= 1'b1;
            end
          end else begin
            pending_q   <= pending_d;
            alu_ready_q <= pending_d;
          end
        end
        OUTPUT: begin
          if (bus.phv_out_ready) begin
            state_q         <= IDLE;
            phv_out_valid_q <= 1'b0;
            phv_in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.phv_in_ready   = phv_in_ready_q;
  assign bus.alu_ready      = alu_ready_q;
  assign bus.phv_out        = phv_q;
  assign bus.phv_out_valid  = phv_out_valid_q;
  assign bus.err_unexpected = err_unexp_q;
  assign bus.err_timeout    = err_tmo_q;

endmodule

// File: tb/tb_phv_result_collector.sv
// Randomized bench for phv_result_collector: each PHV transaction is predicted
// from arrival times per ALU (merge, latency, ready, timeout, error flags).
module tb_phv_result_collector;

  localparam int unsigned NA  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned PW  = 160;
  localparam int unsigned TMO = 8;
  localparam int unsigned TW  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  phv_result_collector_if #(.NUM_ALU(NA), .DATA_WIDTH(DW), .PHV_WIDTH(PW)) bus ();

  phv_result_collector #(
    .NUM_ALU(NA), .DATA_WIDTH(DW), .PHV_WIDTH(PW), .TIMEOUT_CYCLES(TMO), .TMO_W(TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_err = 0;
  int            t_arr [NA];
  logic [DW-1:0] t_res [NA];
  bit            m_unexp = 1'b0;
  bit            m_tmo   = 1'b0;

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rand_phv();
    logic [PW-1:0] v;
    for (int i = 0; i < int'(PW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_reset_state();
    check_eq("rst_in_ready",  PW'(bus.phv_in_ready),   PW'(1'b1));
    check_eq("rst_alu_ready", PW'(bus.alu_ready),      '0);
    check_eq("rst_phv_out",   bus.phv_out,             '0);
    check_eq("rst_out_valid", PW'(bus.phv_out_valid),  '0);
    check_eq("rst_err_unexp", PW'(bus.err_unexpected), '0);
    check_eq("rst_err_tmo",   PW'(bus.err_timeout),    '0);
  endtask

  // One PHV: accept, drive results at COLLECT cycle t_arr[i] (>= TMO means never),
  // optionally pulse all unmasked ALUs at cycle unexp_k, then bp stall cycles.
  task automatic run_txn(input logic [PW-1:0] phv, input logic [NA-1:0] mask,
                         input int bp, input int unexp_k);
    logic [PW-1:0] exp_phv;
    logic [NA-1:0] rdy;
    int            last;
    int            lat;
    int            a;
    exp_phv = phv;
    last    = -1;
    for (int i = 0; i < int'(NA); i++) begin
      if (mask[i]) begin
        if (t_arr[i] < int'(TMO)) exp_phv[i*DW +: DW] = t_res[i];
        else m_tmo = 1'b1;
        a = (t_arr[i] < int'(TMO)) ? t_arr[i] : int'(TMO) - 1;
        if (a > last) last = a;
      end
    end
    lat = (mask == '0) ? 0 : last + 1;

    check_eq("idle_in_ready", PW'(bus.phv_in_ready), PW'(1'b1));
    bus.phv_in       = phv;
    bus.phv_in_mask  = mask;
    bus.phv_in_valid = 1'b1;
    step();
    bus.phv_in_valid = 1'b0;

    for (int k = 0; k < lat; k++) begin
      for (int i = 0; i < int'(NA); i++) rdy[i] = mask[i] && (t_arr[i] >= k);
      check_eq("collect_alu_ready", PW'(bus.alu_ready), PW'(rdy));
      check_eq("collect_out_valid", PW'(bus.phv_out_valid), '0);
      bus.alu_result_valid = '0;
      for (int i = 0; i < int'(NA); i++) begin
        if (mask[i] && t_arr[i] == k) begin
          bus.alu_result_valid[i]      = 1'b1;
          bus.alu_result[i*DW +: DW]   = t_res[i];
        end else if (!mask[i] && k == unexp_k) begin
          bus.alu_result_valid[i]      = 1'b1;
          bus.alu_result[i*DW +: DW]   = $urandom;
          m_unexp = 1'b1;
        end
      end
      step();
      bus.alu_result_valid = '0;
    end

    check_eq("out_valid",     PW'(bus.phv_out_valid),  PW'(1'b1));
    check_eq("out_phv",       bus.phv_out,             exp_phv);
    check_eq("out_alu_ready", PW'(bus.alu_ready),      '0);
    check_eq("out_in_ready",  PW'(bus.phv_in_ready),   '0);
    check_eq("err_timeout",   PW'(bus.err_timeout),    PW'(m_tmo));
    check_eq("err_unexp",     PW'(bus.err_unexpected), PW'(m_unexp));

    // Stall with a competing PHV offered; it must not be taken.
    for (int s = 0; s < bp; s++) begin
      bus.phv_in       = ~phv;
      bus.phv_in_mask  = NA'($urandom);
      bus.phv_in_valid = 1'b1;
      step();
      check_eq("bp_phv_stable", bus.phv_out,            exp_phv);
      check_eq("bp_valid_held", PW'(bus.phv_out_valid), PW'(1'b1));
      check_eq("bp_in_ready",   PW'(bus.phv_in_ready),  '0);
    end
    bus.phv_in_valid  = 1'b0;
    bus.phv_out_ready = 1'b1;
    step();
    bus.phv_out_ready = 1'b0;
    check_eq("drain_valid",    PW'(bus.phv_out_valid), '0);
    check_eq("drain_in_ready", PW'(bus.phv_in_ready),  PW'(1'b1));
  endtask

  initial begin
    logic [NA-1:0] m;
    bus.phv_in           = '0;
    bus.phv_in_mask      = '0;
    bus.phv_in_valid     = 1'b0;
    bus.alu_result       = '0;
    bus.alu_result_valid = '0;
    bus.phv_out_ready    = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    check_reset_state();
    rst_n = 1'b1;

    // Mask zero
    t_arr = '{99, 99, 99, 99};
    t_res = '{32'h0, 32'h0, 32'h0, 32'h0};
    run_txn({5{32'hAAAA_AAAA}}, 4'b0000, 2, -1);

    // Staggered results
    t_arr = '{2, 99, 5, 99};
    t_res = '{32'h1111_1111, 32'h0, 32'h2222_2222, 32'h0};
    run_txn(rand_phv(), 4'b0101, 0, -1);

    // Simultaneous completion
    t_arr = '{0, 0, 0, 0};
    t_res = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_txn(rand_phv(), 4'b1111, 0, -1);

    // Long back-pressure
    t_arr = '{1, 3, 99, 99};
    t_res = '{32'hCAFE_0001, 32'hCAFE_0002, 32'h0, 32'h0};
    run_txn(rand_phv(), 4'b0011, 10, -1);

    // Timeout: ALU1 never answers
    t_arr = '{1, 99, 99, 99};
    t_res = '{32'h5A5A_5A5A, 32'hDEAD_BEEF, 32'h0, 32'h0};
    run_txn(rand_phv(), 4'b0011, 1, -1);

    // Unexpected result on ALU3
    t_arr = '{0, 2, 4, 99};
    t_res = '{32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 32'h0};
    run_txn(rand_phv(), 4'b0111, 0, 1);

    for (int n = 0; n < 40; n++) begin
      m = NA'($urandom);
      for (int i = 0; i < int'(NA); i++) begin
        t_arr[i] = $urandom_range(0, 9);
        t_res[i] = $urandom;
      end
      run_txn(rand_phv(), m, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    // Reset in the middle of COLLECT
    bus.phv_in       = rand_phv();
    bus.phv_in_mask  = 4'b1111;
    bus.phv_in_valid = 1'b1;
    step();
    bus.phv_in_valid = 1'b0;
    step();
    check_eq("mid_alu_ready", PW'(bus.alu_ready), PW'(4'b1111));
    rst_n = 1'b0;
    step();
    check_reset_state();
    rst_n   = 1'b1;
    m_unexp = 1'b0;
    m_tmo   = 1'b0;

    t_arr = '{3, 0, 1, 2};
    t_res = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hF0F0_F0F0};
    run_txn(rand_phv(), 4'b1011, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/phv_result_collector.md
Name: phv_result_collector

Overview:
Sits directly downstream of the stage ALUs. Each ALU drives one container result with a one-cycle valid pulse and waits on its ready_in. The block latches the stage's incoming PHV together with a mask of ALUs that received an action. It merges every expected ALU result into its PHV slot, then presents the assembled PHV to the next stage on a valid/ready handshake. A timeout counter forces out the PHV if an expected ALU never answers.

Parameters:
NUM_ALU, 8, number of ALUs feeding this stage
DATA_WIDTH, 32, width of one container / ALU result
PHV_WIDTH, 1024, total PHV width; must be >= NUM_ALU*DATA_WIDTH
TIMEOUT_CYCLES, 64, maximum cycles spent in COLLECT before a forced output; 0 disables the timeout
TMO_W, 16, width of the timeout counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
phv_in  input  PHV_WIDTH  PHV issued to this stage
phv_in_mask  input  NUM_ALU  bit i set means ALU i will return a result for this PHV
phv_in_valid  input  1  phv_in/phv_in_mask valid
phv_in_ready  output  1  block can accept a PHV
alu_result  input  NUM_ALU*DATA_WIDTH  slot i = ALU i container_out_w
alu_result_valid  input  NUM_ALU  per-ALU one-cycle result pulse
alu_ready  output  NUM_ALU  per-ALU ready_in
phv_out  output  PHV_WIDTH  assembled PHV
phv_out_valid  output  1  phv_out valid
phv_out_ready  input  1  downstream accepts phv_out
err_unexpected  output  1  sticky flag: a result arrived for a non-pending ALU
err_timeout  output  1  sticky flag: a PHV was forced out by the timeout

Behaviour:
- Reset values (all synchronous, rst_n=0): state=IDLE; phv_in_ready=1; alu_ready=0; phv_out=0; phv_out_valid=0; pending=0; timeout counter=0; err_unexpected=0; err_timeout=0. Reset mid-operation discards any held PHV and pending mask.
- All outputs are registered.
- Slot mapping:
  - Result i overwrites phv bits [i*DATA_WIDTH +: DATA_WIDTH].
  - Bits [PHV_WIDTH-1 : NUM_ALU*DATA_WIDTH] pass through unchanged.
  - Slots whose mask bit is 0 keep their phv_in value.
- State IDLE:
  - phv_in_ready=1.
  - On phv_in_valid: latch phv_in into the phv_out register, set pending=phv_in_mask, clear the counter, and set phv_in_ready<=0.
  - If phv_in_mask==0, go to OUTPUT with phv_out_valid<=1 on the next edge; otherwise go to COLLECT.
- State COLLECT:
  - alu_ready[i] <= pending_next[i] while the next state is COLLECT; otherwise 0. Ready is therefore high during an ALU's valid-pulse cycle and drops the cycle after its capture.
  - Each cycle, for every i with alu_result_valid[i] && pending[i]: write slot i and clear pending[i]. Multiple ALUs may complete in the same cycle; all are captured.
  - alu_result_valid[i] with pending[i]=0 is ignored and sets err_unexpected. This rule also applies in IDLE and OUTPUT.
  - When pending_next==0 (including the same-cycle capture of the last result): go to OUTPUT, phv_out_valid<=1, alu_ready<=0.
  - The counter increments once per COLLECT cycle. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 while pending_next!=0, then in that cycle:
    - results arriving that cycle are still captured;
    - go to OUTPUT with the uncaptured slots left at their phv_in values;
    - clear pending;
    - set err_timeout.
- State OUTPUT:
  - phv_out and phv_out_valid are held stable until phv_out_ready.
  - On phv_out_valid && phv_out_ready: phv_out_valid<=0, phv_in_ready<=1, go to IDLE.
- Latency, phv_in accept edge to phv_out_valid=1:
  - 1 cycle for mask==0.
  - Otherwise, 1 cycle after the edge that captures the last result.
- Throughput: at most one PHV in flight; no new PHV is accepted until phv_out is consumed. Back-pressure propagates to the ALUs by keeping alu_ready low.
- Error flags are sticky and cleared only by reset.

Test Plan:
- Mask zero: NUM_ALU=4, phv_in=0xAA..AA, mask=4'b0000 -> phv_out_valid high 1 cycle after accept, phv_out=0xAA..AA, alu_ready stays 0.
- Staggered results: mask=4'b0101, ALU0 returns 0x11111111 at cycle 3, ALU2 returns 0x22222222 at cycle 6 -> phv_out_valid at cycle 7; slot0=0x11111111, slot2=0x22222222, slots 1 and 3 plus upper bits equal phv_in; alu_ready[0] low from cycle 4.
- Simultaneous completion: mask=4'b1111, all four valids pulse in the same cycle with values 1,2,3,4 -> all slots written, OUTPUT on the next edge, pending=0.
- Back-pressure: hold phv_out_ready=0 for 10 cycles after output -> phv_out stable, phv_in_ready=0, a new phv_in_valid is not accepted; raise phv_out_ready -> IDLE next cycle, phv_in_ready=1.
- Timeout: TIMEOUT_CYCLES=8, mask=4'b0011, only ALU0 answers -> forced output exactly 8 cycles after entering COLLECT, slot1 keeps its phv_in value, err_timeout=1 and stays 1.
- Unexpected result plus reset: a valid pulse on ALU3 while its mask bit is 0 -> err_unexpected=1, slot3 unchanged; assert rst_n=0 mid-COLLECT -> all outputs return to reset values the next cycle.
